// File: rtl/i2s_pkg.sv
// Shared types and constants for the i2s_rx_framer serial-audio receiver.
package i2s_pkg;

    typedef enum logic [1:0] {
        MODE_I2S = 2'd0,
        MODE_LJ  = 2'd1,
        MODE_TDM = 2'd2
    } mode_t;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_CHANNELS = 8;
    localparam int CHAN_W       = $clog2(MAX_CHANNELS);

    // The reserved encoding behaves as I2S.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_LJ;
            2'd2:    return MODE_TDM;
            default: return MODE_I2S;
        endcase
    endfunction

endpackage

// File: rtl/i2s_slot_shifter.sv
// Per-slot bit counter and MSB-first sample capture with zero-padded LSBs.
module i2s_slot_shifter #(
    parameter int DATA_SIZE   = 32,
    parameter int SAMPLE_BITS = 24,
    localparam int CNT_W      = $clog2(DATA_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   data,
    output logic [CNT_W-1:0]       bit_cnt,
    output logic [SAMPLE_BITS-1:0] shreg
);

    localparam int IDX_W = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_SIZE);
    localparam logic [CNT_W-1:0] SB   = CNT_W'(SAMPLE_BITS);

    logic [IDX_W-1:0] pos;

    // bit_cnt counts bits already captured, so the next bit lands at SB-1-bit_cnt.
    assign pos = IDX_W'(SB - CNT_W'(1) - bit_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start) begin
            bit_cnt                <= CNT_W'(1);
            shreg                  <= '0;
            shreg[SAMPLE_BITS-1]   <= data;
        end else begin
            if (bit_cnt != FULL) bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt < SB)    shreg[pos] <= data;
        end
    end

endmodule

// File: rtl/i2s_rx_framer.sv
// I2S / left-justified / TDM receiver: WS edge detection, slot lock FSM and frame checks.
// Optional I2S_RX_STEREO_PAIR_EN adds left_data/right_data/pair_valid stereo pairing.
module i2s_rx_framer
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int CHANNELS    = 2
) (
    input  logic                   sck_clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   wordSelect,
    input  logic                   data,
    output logic                   sample_valid,
    output logic [SAMPLE_BITS-1:0] sample_data,
    output logic [CHAN_W-1:0]      sample_chan,
    output logic                   frame_err,
    output logic                   locked
`ifdef I2S_RX_STEREO_PAIR_EN
    ,
    output logic [SAMPLE_BITS-1:0] left_data,
    output logic [SAMPLE_BITS-1:0] right_data,
    output logic                   pair_valid
`endif
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DATA_SIZE);
    localparam logic [CHAN_W-1:0] LAST_SLOT = CHAN_W'(CHANNELS - 1);

    state_t                   state_q, state_n;
    mode_t                    md;
    logic                     ws_d, ws_dd;
    logic [1:0]               mode_q;
    logic                     lost_q, lost_n;
    logic [CHAN_W-1:0]        slot_idx, idx_n, new_idx;
    logic [CNT_W-1:0]         bit_cnt;
    logic [SAMPLE_BITS-1:0]   shreg, data_n;
    logic [CHAN_W-1:0]        chan_n;
    logic                     valid_n, err_n, locked_n;
    logic                     frame_start, slot_start, mode_chg, close_ok, overrun;

    i2s_slot_shifter #(.DATA_SIZE(DATA_SIZE), .SAMPLE_BITS(SAMPLE_BITS)) u_shift (
        .clk(sck_clk), .rst_n(rst_n), .start(slot_start), .data(data),
        .bit_cnt(bit_cnt), .shreg(shreg)
    );

    // Internal TDM slot boundaries only count once locked and not discarding.
    always_comb begin
        md          = decode_mode(mode);
        frame_start = ws_d & ~ws_dd;
        slot_start  = 1'b0;
        new_idx     = slot_idx;
        case (md)
            MODE_LJ: begin
                slot_start = wordSelect ^ ws_d;
                new_idx    = CHAN_W'(wordSelect);
            end
            MODE_TDM: begin
                slot_start = frame_start | (state_q == RUN && !lost_q && bit_cnt == FULL);
                new_idx    = frame_start ? '0 : slot_idx + CHAN_W'(1);
            end
            default: begin
                slot_start = ws_d ^ ws_dd;
                new_idx    = CHAN_W'(ws_d);
            end
        endcase
    end

    always_comb begin
        mode_chg = (state_q == RUN) && (mode != mode_q);
        close_ok = (bit_cnt == FULL);
        overrun  = 1'b0;
        if (md == MODE_TDM) begin
            if (frame_start)                 close_ok = close_ok && (slot_idx == LAST_SLOT);
            else if (slot_idx == LAST_SLOT) begin
                close_ok = 1'b0;
                overrun  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        locked_n = locked;
        lost_n   = lost_q;
        idx_n    = slot_idx;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        data_n   = sample_data;
        chan_n   = sample_chan;
        if (mode_chg) begin
            state_n  = SYNC;
            locked_n = 1'b0;
            lost_n   = 1'b0;
        end else if (slot_start) begin
            idx_n  = new_idx;
            lost_n = 1'b0;
            if (state_q == SYNC) begin
                state_n  = RUN;
                locked_n = 1'b1;
            end else if (!lost_q) begin
                lost_n = overrun;
                if (close_ok) begin
                    valid_n = 1'b1;
                    data_n  = shreg;
                    chan_n  = slot_idx;
                end else begin
                    err_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sck_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            ws_d         <= 1'b0;
            ws_dd        <= 1'b0;
            mode_q       <= 2'd0;
            lost_q       <= 1'b0;
            slot_idx     <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_chan  <= '0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state_q      <= state_n;
            ws_d         <= wordSelect;
            ws_dd        <= ws_d;
            mode_q       <= mode;
            lost_q       <= lost_n;
            slot_idx     <= idx_n;
            sample_valid <= valid_n;
            sample_data  <= data_n;
            sample_chan  <= chan_n;
            frame_err    <= err_n;
            locked       <= locked_n;
        end
    end

`ifdef I2S_RX_STEREO_PAIR_EN
    logic                   left_ok_q, left_ok_n, pair_n;
    logic [SAMPLE_BITS-1:0] left_n, right_n;

    // A pair needs a clean channel-0 close earlier in the same frame.
    always_comb begin
        left_ok_n = left_ok_q;
        left_n    = left_data;
        right_n   = right_data;
        pair_n    = 1'b0;
        if (mode_chg) begin
            left_ok_n = 1'b0;
        end else if (slot_start && state_q == RUN && !lost_q) begin
            if (slot_idx == '0) begin
                left_ok_n = close_ok;
                if (close_ok) left_n = shreg;
            end else if (slot_idx == CHAN_W'(1)) begin
                left_ok_n = 1'b0;
                if (close_ok && left_ok_q) begin
                    pair_n  = 1'b1;
                    right_n = shreg;
                end
            end
        end
    end

    always_ff @(posedge sck_clk or negedge rst_n) begin
        if (!rst_n) begin
            left_ok_q  <= 1'b0;
            left_data  <= '0;
            right_data <= '0;
            pair_valid <= 1'b0;
        end else begin
            left_ok_q  <= left_ok_n;
            left_data  <= left_n;
            right_data <= right_n;
            pair_valid <= pair_n;
        end
    end
`endif

endmodule
